// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings and FSM state type for the wait-state scratch memory.
// Used by peripheral_ahb3_wait_mem and peripheral_ahb3_byte_strobe.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8    = 3'b000;
    localparam logic [2:0] HSIZE_B16   = 3'b001;
    localparam logic [2:0] HSIZE_B32   = 3'b010;
    localparam logic [2:0] HSIZE_B64   = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } ahb_state_t;

    // Data-phase wait count for a beat, chosen by whether it starts a burst (NONSEQ) or continues one (SEQ).
    function automatic logic [3:0] beat_waits(input logic [1:0] trans, input int wait_nonseq, input int wait_seq);
        logic [3:0] waits;
        if (trans == HTRANS_SEQ) waits = 4'(wait_seq);
        else                     waits = 4'(wait_nonseq);
        return waits;
    endfunction

endpackage

// File: rtl/peripheral_ahb3_byte_strobe.sv
// Byte-lane enables for one AHB beat from HSIZE and the low address bits.
// Oversize HSIZE is clamped to full width and offset bits below the transfer size are ignored.
module peripheral_ahb3_byte_strobe
    import peripheral_ahb3_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic [2:0]       size,
    input  logic [OFF_W-1:0] offset,
    output logic [BYTES-1:0] strobe
);

    localparam int MAX_SIZE = $clog2(BYTES);

    int eff_size;
    int nbytes;
    int base;

    always_comb begin
        eff_size = (int'(size) > MAX_SIZE) ? MAX_SIZE : int'(size);
        nbytes   = 1 << eff_size;
        // Aligning the offset down to the transfer size keeps a misaligned beat inside its natural lane group.
        base     = int'(offset) & (BYTES - 1) & ~(nbytes - 1);
        strobe   = '0;
        for (int i = 0; i < BYTES; i++) begin
            strobe[i] = (i >= base) && (i < base + nbytes);
        end
    end

endmodule

// File: rtl/peripheral_ahb3_wait_mem.sv
// AHB3-Lite slave RAM with programmable NONSEQ/SEQ wait states, byte-lane writes and pipelined bursts.
// Define PERIPHERAL_AHB3_ERR_EN to answer oversize, misaligned or out-of-range beats with a two-cycle ERROR.
module peripheral_ahb3_wait_mem
    import peripheral_ahb3_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_NONSEQ = 2,
    parameter int WAIT_SEQ    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES    = HDATA_SIZE / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int OFF_W    = (BYTES > 1) ? ADDR_LSB : 1;
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    ahb_state_t       state;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] addr_idx;
    logic [OFF_W-1:0] addr_off;
    logic [2:0]       size_q;
    logic             write_q;
    logic             err_q;
    logic             ready;
    logic             resp;

    logic             accept;
    logic [3:0]       new_waits;
    logic             err_now;
    logic [BYTES-1:0] strobe;
    logic             unused_sink;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign new_waits = beat_waits(HTRANS, WAIT_NONSEQ, WAIT_SEQ);

`ifdef PERIPHERAL_AHB3_ERR_EN
    logic [OFF_W-1:0] size_mask;

    always_comb begin
        size_mask = '0;
        for (int i = 0; i < OFF_W; i++) begin
            size_mask[i] = (i < int'(HSIZE));
        end
    end

    assign err_now = (int'(HSIZE) > ADDR_LSB)
                   || ((HADDR[OFF_W-1:0] & size_mask) != '0)
                   || ((HADDR >> ADDR_LSB) >= HADDR_SIZE'(MEM_DEPTH));
    assign unused_sink = ^{HBURST, HPROT, HMASTLOCK};
`else
    assign err_now     = 1'b0;
    assign unused_sink = ^{HBURST, HPROT, HMASTLOCK, HADDR};
`endif

    peripheral_ahb3_byte_strobe #(
        .DATA_W (HDATA_SIZE)
    ) u_byte_strobe (
        .size   (size_q),
        .offset (addr_off),
        .strobe (strobe)
    );

    // Beat sequencing: the address phase is only sampled while our own data phase is ready,
    // so a beat accepted in LAST/ERR2 pipelines straight into its own data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            ready    <= 1'b1;
            resp     <= HRESP_OKAY;
            addr_idx <= '0;
            addr_off <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt <= '0;
                        if (err_q) begin
                            state <= ST_ERR1;
                            ready <= 1'b0;
                            resp  <= HRESP_ERROR;
                        end else begin
                            state <= ST_LAST;
                            ready <= 1'b1;
                            resp  <= HRESP_OKAY;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                    ready <= 1'b1;
                    resp  <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        addr_idx <= HADDR[ADDR_LSB +: IDX_W];
                        addr_off <= HADDR[OFF_W-1:0];
                        size_q   <= HSIZE;
                        write_q  <= HWRITE;
                        err_q    <= err_now;
                        if (new_waits != 4'd0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= new_waits;
                            ready    <= 1'b0;
                            resp     <= HRESP_OKAY;
                        end else if (err_now) begin
                            state <= ST_ERR1;
                            ready <= 1'b0;
                            resp  <= HRESP_ERROR;
                        end else begin
                            state <= ST_LAST;
                            ready <= 1'b1;
                            resp  <= HRESP_OKAY;
                        end
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        resp  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Writes commit on the closing edge of LAST, so a following read beat already sees the new data.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_LAST && write_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (strobe[i]) mem[addr_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
            end
        end
    end

    assign HRDATA    = (state == ST_LAST && !write_q) ? mem[addr_idx] : '0;
    assign HREADYOUT = ready;
    assign HRESP     = resp;

endmodule

// File: tb/tb_peripheral_ahb3_wait_mem.sv
// Directed bench for peripheral_ahb3_wait_mem in its default build (WAIT_NONSEQ=2, WAIT_SEQ=0, wrap addressing).
// Single-master bus: HREADY is the slave's own HREADYOUT.
module tb_peripheral_ahb3_wait_mem;
    import peripheral_ahb3_pkg::*;

    localparam int BOUND = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int total = 0;
    int bad   = 0;

    assign HREADY = HREADYOUT;

    always #5 clk = ~clk;

    peripheral_ahb3_wait_mem dut (
        .clk       (clk),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [1:0] trans, input logic [2:0] burst);
        HSEL   = 1'b1;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HTRANS = trans;
        HBURST = burst;
    endtask

    task automatic busIdle();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HBURST = HBURST_SINGLE;
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (HREADYOUT !== 1'b1 && n < BOUND) begin
            n++;
            tick();
        end
        if (n >= BOUND) checkOutput("ready_timeout", {63'd0, HREADYOUT}, 64'd1);
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data, output int waits);
        applyStimulus(1'b1, addr, size, HTRANS_NONSEQ, HBURST_SINGLE);
        tick();
        busIdle();
        HWDATA = data;
        waitReady(waits);
        tick();
    endtask

    task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output int waits);
        applyStimulus(1'b0, addr, HSIZE_B32, HTRANS_NONSEQ, HBURST_SINGLE);
        tick();
        busIdle();
        waitReady(waits);
        data = HRDATA;
        tick();
    endtask

    initial begin
        int          n;
        logic [31:0] rd;
        logic [31:0] burst_exp [4];

        burst_exp[0] = 32'hA0A0A0A0;
        burst_exp[1] = 32'hB1B1B1B1;
        burst_exp[2] = 32'hC2C2C2C2;
        burst_exp[3] = 32'hD3D3D3D3;

        rst       = 1'b1;
        HADDR     = '0;
        HWDATA    = '0;
        HSIZE     = HSIZE_B32;
        HPROT     = 4'b0011;
        HMASTLOCK = 1'b0;
        busIdle();
        repeat (3) tick();
        checkOutput("reset_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        checkOutput("reset_hresp", {63'd0, HRESP}, 64'd0);
        checkOutput("reset_hrdata", {32'd0, HRDATA}, 64'd0);
        rst = 1'b0;
        tick();

        // Single NONSEQ write, then read it back.
        doWrite(32'h10, HSIZE_B32, 32'hDEADBEEF, n);
        checkOutput("write_waits", n, 2);
        doRead(32'h10, rd, n);
        checkOutput("read_waits", n, 2);
        checkOutput("read_data_0x10", {32'd0, rd}, {32'd0, 32'hDEADBEEF});

        // IDLE transfer with HSEL high is a zero-wait OKAY with no data.
        applyStimulus(1'b0, 32'h10, HSIZE_B32, HTRANS_IDLE, HBURST_SINGLE);
        tick();
        busIdle();
        checkOutput("idle_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        checkOutput("idle_hrdata", {32'd0, HRDATA}, 64'd0);

        // INCR4 read: first beat pays NONSEQ waits, the rest stream with no waits.
        for (int b = 0; b < 4; b++) doWrite(32'(b * 4), HSIZE_B32, burst_exp[b], n);
        applyStimulus(1'b0, 32'h0, HSIZE_B32, HTRANS_NONSEQ, HBURST_INCR4);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b < 3) applyStimulus(1'b0, 32'((b + 1) * 4), HSIZE_B32, HTRANS_SEQ, HBURST_INCR4);
            else busIdle();
            waitReady(n);
            checkOutput($sformatf("burst_waits_%0d", b), n, (b == 0) ? 2 : 0);
            checkOutput($sformatf("burst_data_%0d", b), {32'd0, HRDATA}, {32'd0, burst_exp[b]});
            tick();
        end

        // Byte write on lane 3 leaves the other lanes alone.
        doWrite(32'h10, HSIZE_B32, 32'h11223344, n);
        doWrite(32'h13, HSIZE_B8, 32'hAA000000, n);
        doRead(32'h10, rd, n);
        checkOutput("byte_write", {32'd0, rd}, {32'd0, 32'hAA223344});

        // Misaligned halfword at 0x17 is masked down to lanes 2-3.
        doWrite(32'h14, HSIZE_B32, 32'h12345678, n);
        doWrite(32'h17, HSIZE_B16, 32'hCAFE0000, n);
        doRead(32'h14, rd, n);
        checkOutput("half_masked", {32'd0, rd}, {32'd0, 32'hCAFE5678});

        // Back-to-back write then read of the same word, read address issued during write LAST.
        applyStimulus(1'b1, 32'h20, HSIZE_B32, HTRANS_NONSEQ, HBURST_SINGLE);
        tick();
        HWDATA = 32'h0BADF00D;
        applyStimulus(1'b0, 32'h20, HSIZE_B32, HTRANS_NONSEQ, HBURST_SINGLE);
        waitReady(n);
        checkOutput("b2b_write_waits", n, 2);
        tick();
        busIdle();
        checkOutput("b2b_no_bubble", {63'd0, HREADYOUT}, 64'd0);
        waitReady(n);
        checkOutput("b2b_read_waits", n, 2);
        checkOutput("b2b_read_data", {32'd0, HRDATA}, {32'd0, 32'h0BADF00D});
        tick();

        // Address MEM_DEPTH*4 wraps onto word 0.
        doWrite(32'h400, HSIZE_B32, 32'h55AA55AA, n);
        doRead(32'h0, rd, n);
        checkOutput("wrap_data", {32'd0, rd}, {32'd0, 32'h55AA55AA});

        // Reset during the wait of a write drops it.
        applyStimulus(1'b1, 32'h10, HSIZE_B32, HTRANS_NONSEQ, HBURST_SINGLE);
        tick();
        busIdle();
        HWDATA = 32'h99999999;
        checkOutput("pre_reset_wait", {63'd0, HREADYOUT}, 64'd0);
        rst = 1'b1;
        tick();
        checkOutput("mid_reset_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        checkOutput("mid_reset_hresp", {63'd0, HRESP}, 64'd0);
        rst = 1'b0;
        tick();
        doRead(32'h10, rd, n);
        checkOutput("reset_no_write", {32'd0, rd}, {32'd0, 32'hAA223344});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
